alu_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage that directly feeds the 64-bit ALU. It captures a decoded instruction with a valid/ready handshake. It selects operand A (rs1 or PC) and operand B (rs2 or immediate), and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's operand, opcode, format and sub/arith-shift controls.

---
 rtl/alu_operand_stage.sv | 107 ++++++++++
 tb/tb_alu_operand_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX pipeline register with operand forwarding feeding the 64-bit ALU
module alu_operand_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_valid,
  output logic                      out_ready,
  input  logic                      in_ex_ready,
  input  logic                      in_flush,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [3:0]                in_ALU_Op,
  input  logic [1:0]                in_fmt,
  input  logic                      in_sub_aShift_ctrl,
  input  logic                      in_src_a_sel,
  input  logic                      in_src_b_sel,
  input  logic                      in_reg_write,
  input  logic                      in_exmem_reg_write,
  input  logic                      in_memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] in_exmem_rd_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_memwb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     in_exmem_data,
  input  logic [DATA_WIDTH-1:0]     in_memwb_data,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_rs1,
  output logic [DATA_WIDTH-1:0]     out_rs2,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [3:0]                out_ALU_Op,
  output logic [1:0]                out_fmt,
  output logic                      out_sub_aShift_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_reg_write,
  output logic [DATA_WIDTH-1:0]     out_pc
);
  logic valid_q, sub_q, sa_q, sb_q, rw_q, capture, refresh;
  logic [DATA_WIDTH-1:0] pc_q, rs1_q, rs2_q, imm_q, fwd_rs1, fwd_rs2;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic [3:0] op_q;
  logic [1:0] fmt_q;
  assign out_ready = !valid_q || in_ex_ready;
  assign capture = in_valid && out_ready && !in_flush;
  assign refresh = valid_q && !capture && in_memwb_reg_write && in_memwb_rd_addr != '0;
  // Forward the youngest in-flight producer; x0 always reads its held value
  always_comb begin
    fwd_rs1 = (rs1_addr_q != '0 && in_exmem_reg_write && in_exmem_rd_addr == rs1_addr_q) ? in_exmem_data :
              (rs1_addr_q != '0 && in_memwb_reg_write && in_memwb_rd_addr == rs1_addr_q) ? in_memwb_data : rs1_q;
    fwd_rs2 = (rs2_addr_q != '0 && in_exmem_reg_write && in_exmem_rd_addr == rs2_addr_q) ? in_exmem_data :
              (rs2_addr_q != '0 && in_memwb_reg_write && in_memwb_rd_addr == rs2_addr_q) ? in_memwb_data : rs2_q;
  end
  // Valid bit: flush wins, then capture, then drain to downstream
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) valid_q <= 1'b0;
    else valid_q <= in_flush ? 1'b0 : capture ? 1'b1 : (valid_q && in_ex_ready) ? 1'b0 : valid_q;
  end
  // Payload: load on capture, otherwise hold while absorbing MEM/WB writebacks to held sources
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      pc_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q <= '0;
      op_q <= '0;
      fmt_q <= '0;
      sub_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      rw_q <= 1'b0;
    end else if (capture) begin
      pc_q <= in_pc;
      rs1_q <= in_rs1_data;
      rs2_q <= in_rs2_data;
      imm_q <= in_imm;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rd_q <= in_rd_addr;
      op_q <= in_ALU_Op;
      fmt_q <= in_fmt;
      sub_q <= in_sub_aShift_ctrl;
      sa_q <= in_src_a_sel;
      sb_q <= in_src_b_sel;
      rw_q <= in_reg_write;
    end else if (refresh) begin
      if (in_memwb_rd_addr == rs1_addr_q) rs1_q <= in_memwb_data;
      if (in_memwb_rd_addr == rs2_addr_q) rs2_q <= in_memwb_data;
    end
  end
  assign out_valid = valid_q;
  assign out_rs1 = sa_q ? pc_q : fwd_rs1;
  assign out_rs2 = sb_q ? imm_q : fwd_rs2;
  assign out_store_data = fwd_rs2;
  assign out_ALU_Op = op_q;
  assign out_fmt = fmt_q;
  assign out_sub_aShift_ctrl = sub_q;
  assign out_rd_addr = rd_q;
  assign out_reg_write = rw_q && valid_q;
  assign out_pc = pc_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: vector table, corner sequences and randomized model check for alu_operand_stage
module tb_alu_operand_stage;
  logic in_clk, in_rst, in_valid, out_ready, in_ex_ready, in_flush;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0] in_ALU_Op;
  logic [1:0] in_fmt;
  logic in_sub_aShift_ctrl, in_src_a_sel, in_src_b_sel, in_reg_write;
  logic in_exmem_reg_write, in_memwb_reg_write;
  logic [4:0] in_exmem_rd_addr, in_memwb_rd_addr;
  logic [63:0] in_exmem_data, in_memwb_data;
  logic out_valid;
  logic [63:0] out_rs1, out_rs2, out_store_data, out_pc;
  logic [3:0] out_ALU_Op;
  logic [1:0] out_fmt;
  logic out_sub_aShift_ctrl, out_reg_write;
  logic [4:0] out_rd_addr;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready(out_ready),
    .in_ex_ready(in_ex_ready), .in_flush(in_flush), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_ALU_Op(in_ALU_Op), .in_fmt(in_fmt),
    .in_sub_aShift_ctrl(in_sub_aShift_ctrl), .in_src_a_sel(in_src_a_sel), .in_src_b_sel(in_src_b_sel),
    .in_reg_write(in_reg_write), .in_exmem_reg_write(in_exmem_reg_write),
    .in_memwb_reg_write(in_memwb_reg_write), .in_exmem_rd_addr(in_exmem_rd_addr),
    .in_memwb_rd_addr(in_memwb_rd_addr), .in_exmem_data(in_exmem_data), .in_memwb_data(in_memwb_data),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_store_data(out_store_data),
    .out_ALU_Op(out_ALU_Op), .out_fmt(out_fmt), .out_sub_aShift_ctrl(out_sub_aShift_ctrl),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_pc(out_pc)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Reference model: the instruction currently held by the stage
  typedef struct {
    logic v, sa, sb, sub, rw;
    logic [63:0] pc, d1, d2, imm;
    logic [4:0] a1, a2, rd;
    logic [3:0] op;
    logic [1:0] fmt;
  } held_t;
  held_t m;

  typedef struct {
    logic [4:0] a1, a2;
    logic [63:0] d1, d2, pc, imm;
    logic sa, sb;
    logic [3:0] op;
    logic ew;
    logic [4:0] ed;
    logic [63:0] edat;
    logic mw;
    logic [4:0] md;
    logic [63:0] mdat;
    logic [63:0] e1, e2, es;
  } vec_t;
  vec_t vec [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] source_value(input logic [4:0] addr, input logic [63:0] held);
    if (addr == 0) return held;
    if (in_exmem_reg_write && in_exmem_rd_addr == addr) return in_exmem_data;
    if (in_memwb_reg_write && in_memwb_rd_addr == addr) return in_memwb_data;
    return held;
  endfunction

  task automatic model_reset();
    m = '{v: 0, sa: 0, sb: 0, sub: 0, rw: 0, pc: 0, d1: 0, d2: 0, imm: 0, a1: 0, a2: 0, rd: 0, op: 0, fmt: 0};
  endtask

  task automatic model_edge();
    logic accept;
    accept = in_valid && (!m.v || in_ex_ready) && !in_flush;
    if (accept) begin
      m = '{v: 1, sa: in_src_a_sel, sb: in_src_b_sel, sub: in_sub_aShift_ctrl, rw: in_reg_write,
            pc: in_pc, d1: in_rs1_data, d2: in_rs2_data, imm: in_imm, a1: in_rs1_addr, a2: in_rs2_addr,
            rd: in_rd_addr, op: in_ALU_Op, fmt: in_fmt};
    end else begin
      if (m.v && in_memwb_reg_write && in_memwb_rd_addr != 0) begin
        if (in_memwb_rd_addr == m.a1) m.d1 = in_memwb_data;
        if (in_memwb_rd_addr == m.a2) m.d2 = in_memwb_data;
      end
      if (in_flush || in_ex_ready) m.v = 0;
    end
  endtask

  task automatic check_model();
    chk("valid", 64'(out_valid), 64'(m.v));
    chk("ready", 64'(out_ready), 64'(!m.v || in_ex_ready));
    chk("rs1", out_rs1, m.sa ? m.pc : source_value(m.a1, m.d1));
    chk("rs2", out_rs2, m.sb ? m.imm : source_value(m.a2, m.d2));
    chk("store", out_store_data, source_value(m.a2, m.d2));
    chk("op", 64'(out_ALU_Op), 64'(m.op));
    chk("fmt", 64'(out_fmt), 64'(m.fmt));
    chk("sub", 64'(out_sub_aShift_ctrl), 64'(m.sub));
    chk("rd", 64'(out_rd_addr), 64'(m.rd));
    chk("reg_write", 64'(out_reg_write), 64'(m.rw && m.v));
    chk("pc", out_pc, m.pc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge in_clk);
    #1;
  endtask

  task automatic fwd_off();
    in_exmem_reg_write = 0; in_exmem_rd_addr = 0; in_exmem_data = 0;
    in_memwb_reg_write = 0; in_memwb_rd_addr = 0; in_memwb_data = 0;
  endtask

  initial begin
    vec[0] = '{3, 4, 64'd5, 64'd7, 64'h0, 64'h0, 0, 0, 4'b0000, 0, 0, 64'h0, 0, 0, 64'h0, 64'd5, 64'd7, 64'd7};
    vec[1] = '{3, 4, 64'h11, 64'h22, 64'h0, 64'h0, 0, 0, 4'b0001, 1, 3, 64'hAA, 1, 3, 64'hBB, 64'hAA, 64'h22, 64'h22};
    vec[2] = '{3, 4, 64'h11, 64'h22, 64'h0, 64'h0, 0, 0, 4'b0010, 0, 3, 64'hAA, 1, 3, 64'hBB, 64'hBB, 64'h22, 64'h22};
    vec[3] = '{0, 4, 64'h11, 64'h22, 64'h0, 64'h0, 0, 0, 4'b0011, 1, 0, 64'hAA, 1, 0, 64'hBB, 64'h11, 64'h22, 64'h22};
    vec[4] = '{1, 6, 64'h11, 64'h22, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 4'b0100, 1, 6, 64'h55, 0, 0, 64'h0,
               64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h55};
    vec[5] = '{1, 6, 64'h11, 64'h22, 64'h0, 64'h0, 0, 0, 4'b0101, 0, 6, 64'h55, 1, 6, 64'h66, 64'h11, 64'h66, 64'h66};
    vec[6] = '{5, 6, 64'h11, 64'h22, 64'h0, 64'h0, 0, 0, 4'b0110, 1, 7, 64'h55, 1, 6, 64'h66, 64'h11, 64'h66, 64'h66};
    vec[7] = '{9, 9, 64'h11, 64'h22, 64'h0, 64'h9, 0, 1, 4'b1111, 1, 9, 64'h99, 0, 0, 64'h0, 64'h99, 64'h9, 64'h99};

    in_rst = 0; in_valid = 0; in_ex_ready = 1; in_flush = 0;
    in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_ALU_Op = 0; in_fmt = 0;
    in_sub_aShift_ctrl = 0; in_src_a_sel = 0; in_src_b_sel = 0; in_reg_write = 0;
    fwd_off();
    model_reset();
    #1 in_rst = 1;
    #1;
    chk("reset_valid", 64'(out_valid), 0);
    chk("reset_ready", 64'(out_ready), 1);
    chk("reset_rs1", out_rs1, 0);
    chk("reset_rs2", out_rs2, 0);
    chk("reset_store", out_store_data, 0);
    chk("reset_reg_write", 64'(out_reg_write), 0);
    @(negedge in_clk);
    in_rst = 0;

    for (int i = 0; i < 8; i++) begin
      fwd_off();
      in_rs1_addr = vec[i].a1; in_rs2_addr = vec[i].a2;
      in_rs1_data = vec[i].d1; in_rs2_data = vec[i].d2;
      in_pc = vec[i].pc; in_imm = vec[i].imm;
      in_src_a_sel = vec[i].sa; in_src_b_sel = vec[i].sb; in_ALU_Op = vec[i].op;
      in_valid = 1; in_ex_ready = 1;
      tick();
      in_valid = 0;
      in_exmem_reg_write = vec[i].ew; in_exmem_rd_addr = vec[i].ed; in_exmem_data = vec[i].edat;
      in_memwb_reg_write = vec[i].mw; in_memwb_rd_addr = vec[i].md; in_memwb_data = vec[i].mdat;
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("vec%0d_rs1", i), out_rs1, vec[i].e1);
      chk($sformatf("vec%0d_rs2", i), out_rs2, vec[i].e2);
      chk($sformatf("vec%0d_store", i), out_store_data, vec[i].es);
      chk($sformatf("vec%0d_op", i), 64'(out_ALU_Op), 64'(vec[i].op));
    end

    fwd_off();
    in_src_a_sel = 0; in_src_b_sel = 0;
    in_rs1_addr = 1; in_rs2_addr = 2; in_rs1_data = 64'h10; in_rs2_data = 64'h20;
    in_pc = 64'h2000; in_rd_addr = 5; in_reg_write = 1; in_valid = 1; in_ex_ready = 1;
    tick();
    in_pc = 64'hDEAD; in_rs2_data = 64'hBAD; in_ex_ready = 0;
    #1;
    chk("stall_ready_c1", 64'(out_ready), 0);
    tick();
    chk("stall_ready_c2", 64'(out_ready), 0);
    chk("stall_pc_c2", out_pc, 64'h2000);
    chk("stall_rs2_c2", out_rs2, 64'h20);
    in_memwb_reg_write = 1; in_memwb_rd_addr = 2; in_memwb_data = 64'h77;
    #1;
    chk("stall_rs2_fwd", out_rs2, 64'h77);
    tick();
    fwd_off();
    #1;
    chk("stall_rs2_refreshed", out_rs2, 64'h77);
    chk("stall_ready_c3", 64'(out_ready), 0);
    tick();
    chk("stall_rs2_kept", out_rs2, 64'h77);
    chk("stall_pc_kept", out_pc, 64'h2000);
    check_model();
    in_rst = 1;
    #1;
    chk("areset_valid", 64'(out_valid), 0);
    chk("areset_ready", 64'(out_ready), 1);
    chk("areset_rs2", out_rs2, 0);
    chk("areset_pc", out_pc, 0);
    chk("areset_reg_write", 64'(out_reg_write), 0);
    chk("areset_rd", 64'(out_rd_addr), 0);
    in_rst = 0;
    model_reset();
    in_valid = 0; in_ex_ready = 1;
    tick();

    in_valid = 1; in_reg_write = 1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 64'h3000 + 64'(i * 4); in_rd_addr = 5'(i + 1);
      tick();
      chk($sformatf("b2b%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("b2b%0d_pc", i), out_pc, 64'h3000 + 64'(i * 4));
    end
    in_flush = 1; in_pc = 64'h4000;
    tick();
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_reg_write", 64'(out_reg_write), 0);
    in_flush = 0; in_valid = 0;
    tick();

    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_ex_ready = 1'($urandom_range(0, 2) != 0);
      in_flush = 1'($urandom_range(0, 15) == 0);
      in_pc = {$urandom, $urandom}; in_imm = {$urandom, $urandom};
      in_rs1_data = {$urandom, $urandom}; in_rs2_data = {$urandom, $urandom};
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom); in_ALU_Op = 4'($urandom); in_fmt = 2'($urandom);
      in_sub_aShift_ctrl = 1'($urandom); in_src_a_sel = 1'($urandom); in_src_b_sel = 1'($urandom);
      in_reg_write = 1'($urandom);
      in_exmem_reg_write = 1'($urandom); in_exmem_rd_addr = 5'($urandom_range(0, 3));
      in_exmem_data = {$urandom, $urandom};
      in_memwb_reg_write = 1'($urandom); in_memwb_rd_addr = 5'($urandom_range(0, 3));
      in_memwb_data = {$urandom, $urandom};
      #1;
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
